// File: rtl/chaining_record_table.sv
// Chaining record table: tracks per-instruction write-back progress of vector
// destination granules so later instructions can chain on partial results.
module chaining_record_table (
    input  logic        clock,
    input  logic        reset,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    input  logic        alloc_bits_vd_valid,
    input  logic [4:0]  alloc_bits_vd,
    input  logic [2:0]  alloc_bits_instIndex,
    input  logic        write_valid,
    input  logic [2:0]  write_bits_instIndex,
    input  logic [3:0]  write_bits_granule,
    input  logic        retire_valid,
    input  logic [2:0]  retire_bits_instIndex,
    output logic [3:0]  record_valid,
    output logic [3:0]  record_vd_valid,
    output logic [19:0] record_vd_bits,
    output logic [11:0] record_instIndex,
    output logic [63:0] record_elementMask,
    output logic [3:0]  record_done,
    output logic [2:0]  count
);

    localparam int unsigned SLOTS  = 4;
    localparam int unsigned SLOT_W = 2;
    localparam int unsigned VD_W   = 5;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } slotState_t;

    slotState_t           state     [SLOTS];
    slotState_t           stateNext [SLOTS];
    logic                 vdValidQ  [SLOTS];
    logic                 vdValidNext [SLOTS];
    logic [VD_W-1:0]      vdQ       [SLOTS];
    logic [VD_W-1:0]      vdNext    [SLOTS];
    logic [IDX_W-1:0]     instQ     [SLOTS];
    logic [IDX_W-1:0]     instNext  [SLOTS];
    logic [MASK_W-1:0]    maskQ     [SLOTS];
    logic [MASK_W-1:0]    maskNext  [SLOTS];

    logic [SLOTS-1:0]     validQ;
    logic [SLOTS-1:0]     validNext;
    logic [SLOTS-1:0]     doneQ;
    logic [SLOTS-1:0]     doneNext;
    logic [CNT_W-1:0]     countQ;
    logic [CNT_W-1:0]     countNext;

    logic                 anyIdle;
    logic                 dupInst;
    logic                 slotFound;
    logic [SLOT_W-1:0]    allocSlot;
    logic                 allocFire;
    logic [MASK_W-1:0]    maskSet;

    // Free-slot search and duplicate-index guard, from pre-edge state only
    always_comb begin
        anyIdle   = 1'b0;
        dupInst   = 1'b0;
        slotFound = 1'b0;
        allocSlot = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (state[i] == IDLE) begin
                anyIdle = 1'b1;
                if (!slotFound) begin
                    allocSlot = SLOT_W'(i);
                    slotFound = 1'b1;
                end
            end else if (instQ[i] == alloc_bits_instIndex) begin
                dupInst = 1'b1;
            end
        end
        alloc_ready = !reset && anyIdle && !dupInst;
        allocFire   = alloc_valid && alloc_ready;
    end

    // State and record registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                state[i]    <= IDLE;
                vdValidQ[i] <= 1'b0;
                vdQ[i]      <= '0;
                instQ[i]    <= '0;
                maskQ[i]    <= '0;
            end
            validQ <= '0;
            doneQ  <= '0;
            countQ <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                state[i]    <= stateNext[i];
                vdValidQ[i] <= vdValidNext[i];
                vdQ[i]      <= vdNext[i];
                instQ[i]    <= instNext[i];
                maskQ[i]    <= maskNext[i];
            end
            validQ <= validNext;
            doneQ  <= doneNext;
            countQ <= countNext;
        end
    end

    // Next-state: retire beats write; allocation only ever targets an IDLE slot
    always_comb begin
        maskSet = '0;
        for (int i = 0; i < SLOTS; i++) begin
            stateNext[i]   = state[i];
            vdValidNext[i] = vdValidQ[i];
            vdNext[i]      = vdQ[i];
            instNext[i]    = instQ[i];
            maskNext[i]    = maskQ[i];

            if (state[i] != IDLE && retire_valid && instQ[i] == retire_bits_instIndex) begin
                stateNext[i] = IDLE;
                maskNext[i]  = '0;
            end else if (state[i] != IDLE && write_valid && vdValidQ[i] &&
                         instQ[i] == write_bits_instIndex) begin
                maskSet     = maskQ[i] | (MASK_W'(1) << write_bits_granule);
                maskNext[i] = maskSet;
                if (maskSet == {MASK_W{1'b1}}) begin
                    stateNext[i] = DONE;
                end
            end

            if (allocFire && allocSlot == SLOT_W'(i)) begin
                stateNext[i]   = ACTIVE;
                vdValidNext[i] = alloc_bits_vd_valid;
                vdNext[i]      = alloc_bits_vd;
                instNext[i]    = alloc_bits_instIndex;
                maskNext[i]    = '0;
            end
        end
    end

    // Output next values, registered alongside the state
    always_comb begin
        validNext = '0;
        doneNext  = '0;
        countNext = '0;
        for (int i = 0; i < SLOTS; i++) begin
            validNext[i] = (stateNext[i] != IDLE);
            doneNext[i]  = (stateNext[i] == DONE);
            countNext    = countNext + CNT_W'(validNext[i]);
        end
    end

    // Flatten per-slot registers onto the packed output buses
    always_comb begin
        record_vd_valid    = '0;
        record_vd_bits     = '0;
        record_instIndex   = '0;
        record_elementMask = '0;
        for (int i = 0; i < SLOTS; i++) begin
            record_vd_valid[i]                 = vdValidQ[i];
            record_vd_bits[VD_W*i +: VD_W]     = vdQ[i];
            record_instIndex[IDX_W*i +: IDX_W] = instQ[i];
            record_elementMask[MASK_W*i +: MASK_W] = maskQ[i];
        end
    end

    assign record_valid = validQ;
    assign record_done  = doneQ;
    assign count        = countQ;

endmodule

// File: tb/tb_chaining_record_table.sv
// Directed bench for chaining_record_table: stimulus queues expected values,
// a monitor process pops and compares them against the outputs.
module tb_chaining_record_table;

    logic        clock;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_bits_vd_valid;
    logic [4:0]  alloc_bits_vd;
    logic [2:0]  alloc_bits_instIndex;
    logic        write_valid;
    logic [2:0]  write_bits_instIndex;
    logic [3:0]  write_bits_granule;
    logic        retire_valid;
    logic [2:0]  retire_bits_instIndex;
    logic [3:0]  record_valid;
    logic [3:0]  record_vd_valid;
    logic [19:0] record_vd_bits;
    logic [11:0] record_instIndex;
    logic [63:0] record_elementMask;
    logic [3:0]  record_done;
    logic [2:0]  count;

    chaining_record_table dut (
        .clock                (clock),
        .reset                (reset),
        .alloc_valid          (alloc_valid),
        .alloc_ready          (alloc_ready),
        .alloc_bits_vd_valid  (alloc_bits_vd_valid),
        .alloc_bits_vd        (alloc_bits_vd),
        .alloc_bits_instIndex (alloc_bits_instIndex),
        .write_valid          (write_valid),
        .write_bits_instIndex (write_bits_instIndex),
        .write_bits_granule   (write_bits_granule),
        .retire_valid         (retire_valid),
        .retire_bits_instIndex(retire_bits_instIndex),
        .record_valid         (record_valid),
        .record_vd_valid      (record_vd_valid),
        .record_vd_bits       (record_vd_bits),
        .record_instIndex     (record_instIndex),
        .record_elementMask   (record_elementMask),
        .record_done          (record_done),
        .count                (count)
    );

    localparam int F_VALID = 0;
    localparam int F_DONE  = 1;
    localparam int F_COUNT = 2;
    localparam int F_READY = 3;
    localparam int F_MASK  = 4;
    localparam int F_INST  = 5;
    localparam int F_VD    = 6;

    typedef struct packed {
        logic [95:0] name;
        logic [3:0]  field;
        logic [1:0]  slot;
        logic [63:0] value;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    event checkNow;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] actual(input logic [3:0] f, input logic [1:0] s);
        case (int'(f))
            F_VALID: return 64'(record_valid);
            F_DONE:  return 64'(record_done);
            F_COUNT: return 64'(count);
            F_READY: return 64'(alloc_ready);
            F_MASK:  return 64'(record_elementMask[16*s +: 16]);
            F_INST:  return 64'(record_instIndex[3*s +: 3]);
            F_VD:    return 64'(record_vd_bits[5*s +: 5]);
            default: return '1;
        endcase
    endfunction

    // Monitor: compares all pending expectations at each sample point
    always begin
        exp_t e;
        logic [63:0] act;
        @(negedge clock or checkNow);
        while (q.size() > 0) begin
            e = q.pop_front();
            act = actual(e.field, e.slot);
            checks++;
            if (act !== e.value)
                $display("FAIL %s: got %0h want %0h", e.name, act, e.value);
            else
                passes++;
        end
    end

    task automatic want(input logic [95:0] nm, input int f, input int s, input logic [63:0] v);
        q.push_back('{nm, 4'(f), 2'(s), v});
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clearIn();
        alloc_valid  = 1'b0;
        write_valid  = 1'b0;
        retire_valid = 1'b0;
    endtask

    task automatic doAlloc(input logic [2:0] idx, input logic [4:0] vd, input logic vv);
        alloc_valid          = 1'b1;
        alloc_bits_instIndex = idx;
        alloc_bits_vd        = vd;
        alloc_bits_vd_valid  = vv;
    endtask

    task automatic doWrite(input logic [2:0] idx, input logic [3:0] g);
        write_valid          = 1'b1;
        write_bits_instIndex = idx;
        write_bits_granule   = g;
    endtask

    task automatic doRetire(input logic [2:0] idx);
        retire_valid          = 1'b1;
        retire_bits_instIndex = idx;
    endtask

    initial begin
        reset = 1'b0;
        clearIn();
        alloc_bits_vd_valid   = 1'b0;
        alloc_bits_vd         = '0;
        alloc_bits_instIndex  = '0;
        write_bits_instIndex  = '0;
        write_bits_granule    = '0;
        retire_bits_instIndex = '0;
        #1 reset = 1'b1;
        doAlloc(3'd1, 5'd1, 1'b1);
        cyc(); cyc();
        want("rst_valid", F_VALID, 0, 64'h0);
        want("rst_count", F_COUNT, 0, 64'h0);
        want("rst_ready", F_READY, 0, 64'h0);
        cyc();
        reset = 1'b0;
        clearIn();
        want("post_ready", F_READY, 0, 64'h1);
        want("post_count", F_COUNT, 0, 64'h0);

        // Basic allocate and partial write-back
        doAlloc(3'd3, 5'd8, 1'b1);
        cyc(); clearIn();
        for (int g = 0; g < 3; g++) begin
            doWrite(3'd3, 4'(g));
            cyc();
        end
        clearIn();
        want("b_valid", F_VALID, 0, 64'h1);
        want("b_mask0", F_MASK, 0, 64'h0007);
        want("b_done", F_DONE, 0, 64'h0);
        want("b_count", F_COUNT, 0, 64'h1);
        want("b_inst0", F_INST, 0, 64'h3);
        want("b_vd0", F_VD, 0, 64'h8);
        doRetire(3'd3);
        cyc(); clearIn();
        want("b_ret_cnt", F_COUNT, 0, 64'h0);

        // Fill, block, recover
        for (int k = 0; k < 4; k++) begin
            doAlloc(3'(k), 5'(k * 2), 1'b1);
            cyc();
        end
        clearIn();
        alloc_bits_instIndex = 3'd4;
        want("full_ready", F_READY, 0, 64'h0);
        want("full_count", F_COUNT, 0, 64'h4);
        want("full_valid", F_VALID, 0, 64'hF);
        doRetire(3'd2);
        cyc(); clearIn();
        want("rec_valid", F_VALID, 0, 64'hB);
        want("rec_ready", F_READY, 0, 64'h1);
        want("rec_count", F_COUNT, 0, 64'h3);
        doAlloc(3'd4, 5'd16, 1'b1);
        cyc(); clearIn();
        want("slot2_inst", F_INST, 2, 64'h4);
        want("slot2_vd", F_VD, 2, 64'h10);
        want("refill_cnt", F_COUNT, 0, 64'h4);

        // Same-cycle write and retire on inst 1 (slot 1)
        doWrite(3'd1, 4'd3);
        cyc(); clearIn();
        want("wr_mask1", F_MASK, 1, 64'h0008);
        doWrite(3'd1, 4'd5);
        doRetire(3'd1);
        cyc(); clearIn();
        want("wr_ret_val", F_VALID, 0, 64'hD);
        want("wr_ret_mask", F_MASK, 1, 64'h0);
        want("wr_ret_cnt", F_COUNT, 0, 64'h3);
        doRetire(3'd0); cyc();
        doRetire(3'd3); cyc();
        doRetire(3'd4); cyc();
        clearIn();
        want("empty_cnt", F_COUNT, 0, 64'h0);

        // Mask completion on inst 6 in slot 0
        doAlloc(3'd6, 5'd0, 1'b1);
        cyc(); clearIn();
        for (int g = 0; g < 16; g++) begin
            doWrite(3'd6, 4'(g));
            cyc();
            if (g == 14) begin
                want("m15_mask", F_MASK, 0, 64'h7FFF);
                want("m15_done", F_DONE, 0, 64'h0);
            end
        end
        clearIn();
        want("m16_mask", F_MASK, 0, 64'hFFFF);
        want("m16_done", F_DONE, 0, 64'h1);
        cyc();
        want("stay_done", F_DONE, 0, 64'h1);
        doWrite(3'd7, 4'd0);
        cyc(); clearIn();
        want("unk_mask", F_MASK, 0, 64'hFFFF);
        want("unk_valid", F_VALID, 0, 64'h1);
        doAlloc(3'd6, 5'd9, 1'b1);
        want("dup_ready", F_READY, 0, 64'h0);
        cyc(); clearIn();
        want("dup_count", F_COUNT, 0, 64'h1);

        // vd_valid=0 record ignores writes
        doAlloc(3'd5, 5'd4, 1'b0);
        cyc(); clearIn();
        doWrite(3'd5, 4'd0);
        cyc(); clearIn();
        want("novd_mask", F_MASK, 1, 64'h0);
        want("novd_valid", F_VALID, 0, 64'h3);
        want("novd_done", F_DONE, 0, 64'h1);

        // Alloc + retire + write-to-new-inst in one cycle
        doAlloc(3'd2, 5'd12, 1'b1);
        doRetire(3'd6);
        doWrite(3'd2, 4'd0);
        cyc(); clearIn();
        want("ar_valid", F_VALID, 0, 64'h6);
        want("ar_inst2", F_INST, 2, 64'h2);
        want("ar_mask2", F_MASK, 2, 64'h0);
        want("ar_count", F_COUNT, 0, 64'h2);

        // Async reset with three records live
        doAlloc(3'd3, 5'd20, 1'b1);
        cyc(); clearIn();
        want("pre_count", F_COUNT, 0, 64'h3);
        cyc();
        #2 reset = 1'b1;
        #1;
        want("ar_rst_val", F_VALID, 0, 64'h0);
        want("ar_rst_cnt", F_COUNT, 0, 64'h0);
        want("ar_rst_done", F_DONE, 0, 64'h0);
        want("ar_rst_inst", F_INST, 2, 64'h0);
        want("ar_rst_vd", F_VD, 2, 64'h0);
        want("ar_rst_rdy", F_READY, 0, 64'h0);
        -> checkNow;
        #1;
        cyc();
        reset = 1'b0;
        want("rel_ready", F_READY, 0, 64'h1);
        cyc();

        for (int t = 0; t < 100 && q.size() > 0; t++) @(posedge clock);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
